spi_le_receiver: RTL

- Serial-to-parallel receiver for the codebase's latch-enable SPI link: the far end of the spi_master interface (sclk/mosi/le).
- Oversamples sclk, mosi and le in the clk domain and shifts mosi MSB-first while le is low.
- On le deassertion, validates the bit count and presents the captured word with a one-cycle valid pulse.
- Used by on-chip register/peripheral models and as a loopback target for spi_master verification.

---
 rtl/spi_le_pkg.sv | 29 ++
 rtl/spi_le_sync.sv | 31 +++
 rtl/spi_le_receiver.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_le_pkg.sv
// spi_le_pkg: shared definitions for the latch-enable SPI receiver.
//   state_t     - receiver FSM encoding (ARM / IDLE / SHIFT / LATCH)
//   RX_BITS_W   - width of the frame bit counter and rx_bits output
//   RX_BITS_MAX - saturation value of the bit counter
//   sat_inc()   - saturating increment for the bit counter
package spi_le_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int RX_BITS_W = 8;
  localparam logic [RX_BITS_W-1:0] RX_BITS_MAX = 8'd255;

  // Counter increment that sticks at RX_BITS_MAX so long frames still read as "too long".
  function automatic logic [RX_BITS_W-1:0] sat_inc(input logic [RX_BITS_W-1:0] v);
    logic [RX_BITS_W-1:0] r;
    if (v == RX_BITS_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_le_sync.sv
// spi_le_sync: single-bit multi-flop synchroniser with a configurable reset value.
// Ports:
//   clk - destination clock
//   rst - asynchronous reset, active-high; loads RST_VAL into every stage
//   d   - asynchronous input
//   q   - synchronised output (last stage)
// Parameters: STAGES (>= 2) flop count, RST_VAL reset level of every stage.
module spi_le_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_r;

  // Shift chain: d enters at bit 0, q is taken from the top bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_r <= {STAGES{RST_VAL}};
    end else begin
      ff_r <= {ff_r[STAGES-2:0], d};
    end
  end

  assign q = ff_r[STAGES-1];

endmodule

// File: rtl/spi_le_receiver.sv
// spi_le_receiver: oversampling serial-to-parallel receiver for the latch-enable
// SPI link (far end of spi_master). mosi is shifted in MSB-first on each sclk
// rising edge while le is low; the le rising edge checks the bit count and
// either publishes the word (rx_valid) or flags it (rx_err).
// Ports:
//   clk, rst           - system clock, asynchronous active-high reset
//   spi_sclk/mosi/le   - serial inputs (CPOL=0, CPHA=0, le active-low window)
//   spi_miso           - readback of the previous valid frame when built with
//                        SPI_LE_RX_MISO_EN, otherwise constant 0
//   rx_data            - last valid frame, held until the next valid frame
//   rx_valid / rx_err  - one-clk pulses for a good / wrong-length frame
//   rx_bits            - bit count of the last completed frame (saturates at 255)
//   busy               - high while a frame is being shifted in
// Optional feature macro: SPI_LE_RX_MISO_EN (builds the miso tx shift register).
module spi_le_receiver
  import spi_le_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_le,
  output logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic [7:0]        rx_bits,
  output logic              busy
);

  localparam logic [RX_BITS_W-1:0] FRAME_BITS = RX_BITS_W'(DATA_W);
  localparam int                   ARM_W      = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [ARM_W-1:0]     ARM_TARGET = ARM_W'(SYNC_STAGES);

  logic sclk_s, mosi_s, le_s;
  logic sclk_d_r, le_d_r;
  logic sclk_rise_s, le_rise_s, le_fall_s;

  state_t state_r, state_next_s;

  logic [DATA_W-1:0]    shift_r;
  logic [DATA_W:0]      shift_ext_s;
  logic [RX_BITS_W-1:0] cnt_r;
  logic [ARM_W-1:0]     arm_cnt_r;
  logic                 arm_done_s;
  logic                 shift_en_s;
  logic                 clear_s;
  logic                 latch_s;
  logic                 frame_ok_s;

  logic [DATA_W-1:0]    rx_data_r;
  logic                 rx_valid_r;
  logic                 rx_err_r;
  logic [RX_BITS_W-1:0] rx_bits_r;

  spi_le_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (spi_sclk), .q (sclk_s)
  );

  spi_le_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (spi_mosi), .q (mosi_s)
  );

  spi_le_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
    .clk (clk), .rst (rst), .d (spi_le), .q (le_s)
  );

  // History flops for edge detection on the synchronised sclk and le.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_d_r <= 1'b0;
      le_d_r   <= 1'b1;
    end else begin
      sclk_d_r <= sclk_s;
      le_d_r   <= le_s;
    end
  end

  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign le_rise_s   = le_s & ~le_d_r;
  assign le_fall_s   = ~le_s & le_d_r;

  // The le synchroniser comes out of reset holding 1s that never came from the
  // pin. ARM only trusts le=1 once it has been high for SYNC_STAGES+1 cycles,
  // i.e. after the chain has been refilled from the pin, so a frame already in
  // progress at reset release stays rejected until le genuinely returns high.
  assign arm_done_s = le_s & (arm_cnt_r == ARM_TARGET);

  // Consecutive-high counter used only while arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt_r <= '0;
    end else if ((state_r == ST_ARM) && le_s) begin
      if (!arm_done_s) begin
        arm_cnt_r <= arm_cnt_r + ARM_W'(1);
      end else begin
        arm_cnt_r <= arm_cnt_r;
      end
    end else begin
      arm_cnt_r <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_ARM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_ARM: begin
        if (arm_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (le_fall_s) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (le_rise_s) begin
          state_next_s = ST_LATCH;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_LATCH: begin
        // A new frame may start immediately after the latch cycle.
        if (le_fall_s) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_ARM;
      end
    endcase
  end

  // Datapath strobes decoded from the FSM; an sclk edge coinciding with the
  // le rising edge is dropped.
  always_comb begin
    shift_en_s = 1'b0;
    clear_s    = 1'b0;
    latch_s    = 1'b0;
    frame_ok_s = 1'b0;
    if ((state_r == ST_SHIFT) && sclk_rise_s && !le_rise_s) begin
      shift_en_s = 1'b1;
    end else begin
      shift_en_s = 1'b0;
    end
    if ((state_next_s == ST_SHIFT) && (state_r != ST_SHIFT)) begin
      clear_s = 1'b1;
    end else begin
      clear_s = 1'b0;
    end
    if (state_r == ST_LATCH) begin
      latch_s    = 1'b1;
      frame_ok_s = (cnt_r == FRAME_BITS);
    end else begin
      latch_s    = 1'b0;
      frame_ok_s = 1'b0;
    end
  end

  // Appending mosi and dropping the top bit keeps the newest DATA_W bits,
  // which also covers DATA_W=1 without a zero-width slice.
  assign shift_ext_s = {shift_r, mosi_s};

  // Shift register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (clear_s) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (shift_en_s) begin
      shift_r <= shift_ext_s[DATA_W-1:0];
      cnt_r   <= sat_inc(cnt_r);
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  // Output registers: publish or reject the frame in the LATCH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      rx_bits_r  <= '0;
    end else if (latch_s) begin
      rx_bits_r <= cnt_r;
      if (frame_ok_s) begin
        rx_data_r  <= shift_r;
        rx_valid_r <= 1'b1;
        rx_err_r   <= 1'b0;
      end else begin
        rx_data_r  <= rx_data_r;
        rx_valid_r <= 1'b0;
        rx_err_r   <= 1'b1;
      end
    end else begin
      rx_data_r  <= rx_data_r;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      rx_bits_r  <= rx_bits_r;
    end
  end

  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign rx_err   = rx_err_r;
  assign rx_bits  = rx_bits_r;
  assign busy     = (state_r == ST_SHIFT);

`ifdef SPI_LE_RX_MISO_EN
  logic              sclk_fall_s;
  logic [DATA_W-1:0] tx_r;
  logic [DATA_W:0]   tx_ext_s;

  assign sclk_fall_s = ~sclk_s & sclk_d_r;
  assign tx_ext_s    = {tx_r, 1'b0};

  // Readback shifter. On a back-to-back entry from LATCH, load the word that
  // rx_data is taking on this same edge rather than its stale value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_r <= '0;
    end else if (clear_s) begin
      if (frame_ok_s) begin
        tx_r <= shift_r;
      end else begin
        tx_r <= rx_data_r;
      end
    end else if ((state_r == ST_SHIFT) && sclk_fall_s) begin
      tx_r <= tx_ext_s[DATA_W-1:0];
    end else begin
      tx_r <= tx_r;
    end
  end

  assign spi_miso = (state_r == ST_SHIFT) ? tx_r[DATA_W-1] : 1'b0;
`else
  assign spi_miso = 1'b0;
`endif

endmodule
